// File: rtl/bus_arbiter_sp.sv
// bus_arbiter_sp: two-master round-robin bus arbiter with single outstanding split transaction support
module bus_arbiter_sp (
    input  logic clk,
    input  logic rst_n,
    input  logic m1_req,
    input  logic m2_req,
    input  logic split,
    input  logic split_req,
    input  logic ready,
    output logic m1_grant,
    output logic m2_grant,
    output logic bus_sel,
    output logic split_grant,
    output logic split_pending,
    output logic split_err
);
    typedef enum logic [1:0] {IDLE, M1_BUS, M2_BUS, RESUME} state_t;
    state_t state, nxt;
    logic owner, prio;
    logic m1_elig, m2_elig, split_hit;
    logic nxt_owner, nxt_prio, nxt_pending, nxt_err, nxt_sel, nxt_m1, nxt_m2, nxt_sg;
    // a master that owns the outstanding split must wait for the slave to resume it
    assign m1_elig   = m1_req && !(split_pending && !owner);
    assign m2_elig   = m2_req && !(split_pending && owner);
    assign split_hit = split && (state == M1_BUS || state == M2_BUS);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (split_req && split_pending) nxt = RESUME;
                else if (m1_elig && (!prio || !m2_elig)) nxt = M1_BUS;
                else if (m2_elig) nxt = M2_BUS;
            end
            M1_BUS:  if (split || !m1_req) nxt = IDLE;
            M2_BUS:  if (split || !m2_req) nxt = IDLE;
            RESUME:  if (ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        nxt_pending = split_hit ? 1'b1 : (state == RESUME && ready) ? 1'b0 : split_pending;
        nxt_owner   = (split_hit && !split_pending) ? (state == M2_BUS) : owner;
        nxt_err     = split_err || (split_hit && split_pending);
        nxt_prio    = (nxt == M1_BUS) ? 1'b1 : (nxt == M2_BUS) ? 1'b0 : prio;
        nxt_sel     = (nxt == M1_BUS) ? 1'b0 : (nxt == M2_BUS) ? 1'b1 : (nxt == RESUME) ? owner : bus_sel;
        nxt_m1      = (nxt == M1_BUS) || (nxt == RESUME && !owner);
        nxt_m2      = (nxt == M2_BUS) || (nxt == RESUME && owner);
        nxt_sg      = (nxt == RESUME);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= 1'b0;
            prio          <= 1'b0;
            m1_grant      <= 1'b0;
            m2_grant      <= 1'b0;
            bus_sel       <= 1'b0;
            split_grant   <= 1'b0;
            split_pending <= 1'b0;
            split_err     <= 1'b0;
        end else begin
            owner         <= nxt_owner;
            prio          <= nxt_prio;
            m1_grant      <= nxt_m1;
            m2_grant      <= nxt_m2;
            bus_sel       <= nxt_sel;
            split_grant   <= nxt_sg;
            split_pending <= nxt_pending;
            split_err     <= nxt_err;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_sp.sv
// tb_bus_arbiter_sp: directed scoreboard bench for the split-capable bus arbiter
module tb_bus_arbiter_sp;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic m1_req = 1'b0, m2_req = 1'b0, split = 1'b0, split_req = 1'b0, ready = 1'b0;
    logic m1_grant, m2_grant, bus_sel, split_grant, split_pending, split_err;
    logic [5:0] exp_q[$];
    string name_q[$];
    int checks = 0;
    int errors = 0;

    bus_arbiter_sp dut (
        .clk(clk), .rst_n(rst_n), .m1_req(m1_req), .m2_req(m2_req), .split(split),
        .split_req(split_req), .ready(ready), .m1_grant(m1_grant), .m2_grant(m2_grant),
        .bus_sel(bus_sel), .split_grant(split_grant), .split_pending(split_pending),
        .split_err(split_err)
    );

    always #5 clk = ~clk;

    // outputs packed as {m1_grant, m2_grant, bus_sel, split_grant, split_pending, split_err}
    always @(posedge clk or negedge rst_n) begin
        #2;
        if (exp_q.size() > 0) begin
            logic [5:0] e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {m1_grant, m2_grant, bus_sel, split_grant, split_pending, split_err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, a, e);
            end
        end
    end

    // inputs packed as {m1_req, m2_req, split, split_req, ready}
    task automatic cyc(input logic [4:0] in, input logic [5:0] e, input string n);
        @(negedge clk);
        {m1_req, m2_req, split, split_req, ready} = in;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
    endtask

    initial begin
        #2;
        exp_q.push_back(6'b000000);
        name_q.push_back("reset");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(5'b10000, 6'b100000, "m1_first_grant");
        cyc(5'b10000, 6'b100000, "m1_hold");
        cyc(5'b00000, 6'b000000, "m1_release");
        cyc(5'b01000, 6'b011000, "m2_grant");
        cyc(5'b00000, 6'b001000, "idle_bus_sel_hold");
        cyc(5'b11000, 6'b100000, "both_prio0_m1");
        cyc(5'b01000, 6'b000000, "m1_drop_idle_gap");
        cyc(5'b01000, 6'b011000, "m2_after_gap");
        cyc(5'b11100, 6'b001010, "m2_split");
        cyc(5'b11000, 6'b100010, "m2_blocked_m1_granted");
        cyc(5'b11010, 6'b100010, "split_req_no_preempt_a");
        cyc(5'b11010, 6'b100010, "split_req_no_preempt_b");
        cyc(5'b01010, 6'b000010, "m1_drop_to_idle");
        cyc(5'b01010, 6'b011110, "resume_grant");
        cyc(5'b00110, 6'b011110, "resume_ignores_split_req_low");
        cyc(5'b00001, 6'b001000, "resume_ready_release");
        cyc(5'b01000, 6'b011000, "m2_grant_again");
        cyc(5'b01100, 6'b001010, "m2_split_again");
        cyc(5'b10001, 6'b100010, "m1_ready_ignored");
        cyc(5'b10100, 6'b000011, "split_while_pending_err");
        cyc(5'b00010, 6'b011111, "owner_kept_resume");
        cyc(5'b00010, 6'b011111, "err_sticky_resume");
        @(negedge clk);
        #2;
        exp_q.push_back(6'b000000);
        name_q.push_back("async_reset_mid_resume");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5'b00010, 6'b000000, "split_req_ignored_after_reset");
        cyc(5'b01010, 6'b011000, "m2_after_reset");
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_sp.md
BUS_ARBITER_SP -- requirements
Module: bus_arbiter_sp

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port m1_req, input, 1, master 1 bus request, held high for the whole transaction.
REQ-004 The block SHALL have port m2_req, input, 1, master 2 bus request, same rules as m1_req.
REQ-005 The block SHALL have port split, input, 1, split indication from the addressed slave.
REQ-006 The block SHALL have port split_req, input, 1, resume request from the split slave; held until granted.
REQ-007 The block SHALL have port ready, input, 1, slave transfer-complete pulse.
REQ-008 The block SHALL have port m1_grant, output, 1, master 1 owns the bus.
REQ-009 The block SHALL have port m2_grant, output, 1, master 2 owns the bus.
REQ-010 The block SHALL have port bus_sel, output, 1, bus mux select: 0 = master 1, 1 = master 2.
REQ-011 The block SHALL have port split_grant, output, 1, resume grant to the split slave.
REQ-012 The block SHALL have port split_pending, output, 1, one split transaction outstanding.
REQ-013 The block SHALL have port split_err, output, 1, sticky flag: split received while one was already pending.

Function
REQ-014 All outputs SHALL be registered and change only on rising clk edges or on reset.
REQ-015 The FSM SHALL have states IDLE, M1_BUS, M2_BUS and RESUME; at most one grant is high in any cycle.
REQ-016 Internal state SHALL comprise a 1-bit owner (the split master) and a 1-bit round-robin pointer (prio); prio = 0 favours master 1.
REQ-017 A master SHALL be eligible when its req is high and it is not (split_pending and owner equal to that master).
REQ-018 In IDLE, priority SHALL be:
- split_req && split_pending: go to RESUME.
- else the eligible master favoured by prio.
- else the single eligible master.
- else stay in IDLE.
REQ-019 Grant latency SHALL be one cycle: when a request is sampled in IDLE, the grant is high and bus_sel is valid from the next edge.
REQ-020 On entering M1_BUS or M2_BUS, prio SHALL point to the other master.
REQ-021 In Mx_BUS with req high and split low, the grant SHALL be held.
REQ-022 In Mx_BUS with req sampled low, the grant SHALL drop on the next edge and the FSM SHALL return to IDLE, giving one idle cycle between owners.
REQ-023 In Mx_BUS with split sampled high and split_pending = 0, the block SHALL set split_pending, set owner = x, drop the grant and go to IDLE; split wins over a simultaneous req drop.
REQ-024 In Mx_BUS with split sampled high and split_pending = 1, the block SHALL set split_err, drop the grant and go to IDLE, leaving owner and split_pending unchanged.
REQ-025 In RESUME, split_grant and the owner's grant SHALL be high and bus_sel SHALL equal owner, regardless of the owner's req.
REQ-026 In RESUME, when ready is sampled high, the block SHALL clear split_pending and all grants and split_grant on the next edge, and go to IDLE.
REQ-027 In RESUME, split SHALL be ignored.
REQ-028 split_req SHALL be ignored while split_pending = 0, and SHALL not pre-empt M1_BUS or M2_BUS; it is served only from IDLE.
REQ-029 ready SHALL be ignored outside RESUME.
REQ-030 bus_sel SHALL hold its last value in IDLE.
REQ-031 split_err SHALL clear only on reset.

Reset
REQ-032 When rst_n is low, the block SHALL immediately force state = IDLE and prio = 0, independent of clk.
REQ-033 When rst_n is low, the block SHALL immediately force owner = 0 and all outputs (m1_grant, m2_grant, bus_sel, split_grant, split_pending, split_err) to 0, independent of clk.
REQ-034 Reset asserted mid-transaction or mid-RESUME SHALL abandon the outstanding split without any further handshake.
REQ-035 Operation SHALL resume on the first rising edge after rst_n goes high.

Verification
REQ-036 The bench SHALL cover: reset, then m1_req = 1 at edge 0 -> m1_grant = 1 and bus_sel = 0 after edge 0; m2_grant = 0.
REQ-037 The bench SHALL cover: m1_req = m2_req = 1 with prio = 0 -> m1 granted; m1_req low -> m1_grant = 0 next edge, one IDLE cycle, then m2_grant = 1 and bus_sel = 1.
REQ-038 The bench SHALL cover: m2 granted, split pulsed -> next edge m2_grant = 0, split_pending = 1; with m2_req still high, m2 is not granted and m1_req is granted.
REQ-039 The bench SHALL cover: split_req = 1 during the m1 transfer -> no pre-emption; after m1_req drops, edge 1 -> IDLE and edge 2 -> m2_grant = 1, bus_sel = 1, split_grant = 1; ready pulse -> next edge all grants = 0 and split_pending = 0.
REQ-040 The bench SHALL cover: split pulsed during the m1 transfer while split_pending = 1 -> split_err = 1 (sticky), m1_grant = 0 next edge, owner unchanged.
REQ-041 The bench SHALL cover: rst_n low mid-RESUME, asynchronous to clk -> all outputs 0 immediately, and a later split_req is ignored.
